// File: rtl/fb_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_write_arbiter: shares one single-port framebuffer RAM between a FIFO'd |
// | pixel write stream and a priority scanout reader.   Revision: 1.0        |
// +--------------------------------------------------------------------------+
module fb_write_arbiter #(
  parameter int WIDTH     = 16,
  parameter int XBITS     = 10,
  parameter int YBITS     = 10,
  parameter int H_PIXELS  = 1024,
  parameter int V_PIXELS  = 768,
  parameter int DEPTH     = 8,
  parameter int MAX_READS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [WIDTH-1:0]       wr_x,
  input  logic [WIDTH-1:0]       wr_y,
  input  logic [15:0]            wr_pixel,
  input  logic                   rd_req,
  input  logic [XBITS+YBITS-1:0] rd_addr,
  output logic                   rd_ack,
  output logic                   rd_valid,
  output logic [15:0]            rd_data,
  output logic [XBITS+YBITS-1:0] ram_addr,
  output logic                   ram_we,
  output logic [15:0]            ram_wdata,
  input  logic [15:0]            ram_rdata,
  output logic [15:0]            dropped
);

  localparam int c_aw    = $clog2(DEPTH);
  localparam int c_abits = XBITS + YBITS;
  localparam int c_ew    = c_abits + 16;
  localparam int c_sw    = $clog2(MAX_READS + 1);

  localparam logic [WIDTH-1:0] c_h_lim  = WIDTH'(H_PIXELS);
  localparam logic [WIDTH-1:0] c_v_lim  = WIDTH'(V_PIXELS);
  localparam logic [c_sw-1:0]  c_streak_max = c_sw'(MAX_READS);

  localparam logic [1:0] c_GRANT_IDLE  = 2'd0;
  localparam logic [1:0] c_GRANT_READ  = 2'd1;
  localparam logic [1:0] c_GRANT_WRITE = 2'd2;

  logic [c_ew-1:0]    r_mem [DEPTH];
  logic [c_aw:0]      r_wptr;
  logic [c_aw:0]      r_rptr;
  logic [c_sw-1:0]    r_streak;
  logic               r_rd_ack;
  logic               r_rd_valid;
  logic               r_ram_we;
  logic [c_abits-1:0] r_ram_addr;
  logic [15:0]        r_ram_wdata;
  logic [15:0]        r_dropped;

  logic               w_empty;
  logic               w_full;
  logic               w_in_range;
  logic               w_accept;
  logic               w_push;
  logic               w_drop;
  logic               w_rd_masked;
  logic               w_rd_live;
  logic [1:0]         w_grant;
  logic [c_ew-1:0]    w_head;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                   (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);

  assign wr_ready   = reset_n && !w_full;
  assign w_in_range = (wr_x < c_h_lim) && (wr_y < c_v_lim);
  assign w_accept   = wr_valid && wr_ready;
  assign w_push     = w_accept && w_in_range;
  assign w_drop     = w_accept && !w_in_range;
  assign w_head     = r_mem[r_rptr[c_aw-1:0]];

  // The request just acknowledged is still on the bus this cycle; a new
  // address means the requester has already moved on to its next word.
  assign w_rd_masked = r_rd_ack && (rd_addr == r_ram_addr);
  assign w_rd_live   = rd_req && !w_rd_masked;

  always_comb begin
    w_grant = c_GRANT_IDLE;
    if (w_rd_live && !((r_streak == c_streak_max) && !w_empty)) begin
      w_grant = c_GRANT_READ;
    end else if (!w_empty) begin
      w_grant = c_GRANT_WRITE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[c_aw-1:0]] <= {wr_y[YBITS-1:0], wr_x[XBITS-1:0], wr_pixel};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_streak    <= '0;
      r_rd_ack    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_dropped   <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_grant == c_GRANT_WRITE) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_drop && (r_dropped != 16'hFFFF)) begin
        r_dropped <= r_dropped + 16'd1;
      end
      r_rd_ack   <= (w_grant == c_GRANT_READ);
      r_rd_valid <= r_rd_ack;
      r_ram_we   <= (w_grant == c_GRANT_WRITE);
      case (w_grant)
        c_GRANT_READ: begin
          r_ram_addr <= rd_addr;
          if (w_empty) begin
            r_streak <= '0;
          end else if (r_streak != c_streak_max) begin
            r_streak <= r_streak + 1'b1;
          end
        end
        c_GRANT_WRITE: begin
          r_ram_addr  <= w_head[c_ew-1:16];
          r_ram_wdata <= w_head[15:0];
          r_streak    <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign rd_ack    = r_rd_ack;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_valid ? ram_rdata : 16'h0000;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign dropped   = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// Directed testbench for fb_write_arbiter; the RAM model returns addr[15:0]^A5A5
// one cycle after the address is presented.
module tb_fb_write_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_x;
  logic [15:0] wr_y;
  logic [15:0] wr_pixel;
  logic        rd_req;
  logic [19:0] rd_addr;
  logic        rd_ack;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [19:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = 16'h0000;
  logic [15:0] dropped;

  int n_cmp = 0;
  int n_err = 0;

  fb_write_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_pixel(wr_pixel),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_rdata <= ram_addr[15:0] ^ 16'hA5A5;

  task automatic test_reset();
    reset_n = 1'b0; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_pixel = '0;
    rd_req = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({wr_ready, rd_ack, rd_valid, ram_we} !== 4'b0000) begin n_err++;
      $display("FAIL rst_flags: got %b expected 0000", {wr_ready, rd_ack, rd_valid, ram_we}); end
    n_cmp++; if (rd_data !== 16'h0) begin n_err++; $display("FAIL rst_rd_data: got %h expected 0000", rd_data); end
    n_cmp++; if (ram_addr !== 20'h0) begin n_err++; $display("FAIL rst_ram_addr: got %h expected 00000", ram_addr); end
    n_cmp++; if (ram_wdata !== 16'h0) begin n_err++; $display("FAIL rst_ram_wdata: got %h expected 0000", ram_wdata); end
    n_cmp++; if (dropped !== 16'h0) begin n_err++; $display("FAIL rst_dropped: got %0d expected 0", dropped); end
    reset_n = 1'b1;
  endtask

  task automatic test_write_basic();
    @(negedge clk);
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL wb_ready: got %b expected 1", wr_ready); end
    wr_valid = 1'b1; wr_x = 16'd5; wr_y = 16'd2; wr_pixel = 16'hF800;
    @(negedge clk);
    wr_valid = 1'b0;
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL wb_we_early: got %b expected 0", ram_we); end
    @(negedge clk);
    n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL wb_we: got %b expected 1", ram_we); end
    n_cmp++; if (ram_addr !== 20'h00805) begin n_err++; $display("FAIL wb_addr: got %h expected 00805", ram_addr); end
    n_cmp++; if (ram_wdata !== 16'hF800) begin n_err++; $display("FAIL wb_wdata: got %h expected f800", ram_wdata); end
    n_cmp++; if (rd_ack !== 1'b0) begin n_err++; $display("FAIL wb_ack: got %b expected 0", rd_ack); end
    @(negedge clk);
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL wb_we_after: got %b expected 0", ram_we); end
    n_cmp++; if (dropped !== 16'd0) begin n_err++; $display("FAIL wb_dropped: got %0d expected 0", dropped); end
  endtask

  task automatic test_drop();
    @(negedge clk);
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL drop_ready0: got %b expected 1", wr_ready); end
    wr_valid = 1'b1; wr_x = 16'd1024; wr_y = 16'd0; wr_pixel = 16'h1234;
    @(negedge clk);
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL drop_ready1: got %b expected 1", wr_ready); end
    n_cmp++; if (dropped !== 16'd1) begin n_err++; $display("FAIL drop_cnt1: got %0d expected 1", dropped); end
    wr_x = 16'd0; wr_y = 16'd768;
    @(negedge clk);
    wr_valid = 1'b0;
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL drop_ready2: got %b expected 1", wr_ready); end
    n_cmp++; if (dropped !== 16'd2) begin n_err++; $display("FAIL drop_cnt2: got %0d expected 2", dropped); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL drop_we i=%0d: got %b expected 0", i, ram_we); end
      @(negedge clk);
    end
  endtask

  // Two writes to the same pixel, back to back: both land, in order.
  task automatic test_back_to_back();
    @(negedge clk);
    wr_valid = 1'b1; wr_x = 16'd9; wr_y = 16'd9; wr_pixel = 16'h1111;
    @(negedge clk);
    wr_pixel = 16'h2222;
    @(negedge clk);
    wr_valid = 1'b0;
    n_cmp++; if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 20'h02409, 16'h1111}) begin n_err++;
      $display("FAIL b2b_first: got we=%b addr=%h data=%h expected we=1 addr=02409 data=1111", ram_we, ram_addr, ram_wdata); end
    @(negedge clk);
    n_cmp++; if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 20'h02409, 16'h2222}) begin n_err++;
      $display("FAIL b2b_second: got we=%b addr=%h data=%h expected we=1 addr=02409 data=2222", ram_we, ram_addr, ram_wdata); end
    @(negedge clk);
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b expected 0", ram_we); end
  endtask

  // Read and write arrive together; requester keeps the same request up during rd_ack.
  task automatic test_read_write_collision();
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 20'h12345;
    wr_valid = 1'b1; wr_x = 16'd7; wr_y = 16'd3; wr_pixel = 16'h07E0;
    @(negedge clk);
    wr_valid = 1'b0;
    n_cmp++; if ({rd_ack, ram_we} !== 2'b10) begin n_err++; $display("FAIL col_grant1: got ack,we=%b expected 10", {rd_ack, ram_we}); end
    n_cmp++; if (ram_addr !== 20'h12345) begin n_err++; $display("FAIL col_raddr: got %h expected 12345", ram_addr); end
    @(negedge clk);
    rd_req = 1'b0;
    n_cmp++; if ({rd_ack, ram_we} !== 2'b01) begin n_err++; $display("FAIL col_grant2: got ack,we=%b expected 01", {rd_ack, ram_we}); end
    n_cmp++; if ({ram_addr, ram_wdata} !== {20'h00C07, 16'h07E0}) begin n_err++;
      $display("FAIL col_write: got addr=%h data=%h expected addr=00c07 data=07e0", ram_addr, ram_wdata); end
    n_cmp++; if ({rd_valid, rd_data} !== {1'b1, 16'h86E0}) begin n_err++;
      $display("FAIL col_rdata: got valid=%b data=%h expected valid=1 data=86e0", rd_valid, rd_data); end
    @(negedge clk);
    n_cmp++; if ({rd_ack, ram_we, rd_valid} !== 3'b000) begin n_err++;
      $display("FAIL col_idle: got ack,we,valid=%b expected 000", {rd_ack, ram_we, rd_valid}); end
  endtask

  // Continuous reads with a write offered every cycle: grants R x5, then W every 5th cycle.
  task automatic test_fill_streak();
    logic [19:0] raddr;
    logic [15:0] acked;
    bit exp_we, exp_ack, exp_rdy, prev_ack;
    int nw;
    raddr = 20'h40000; acked = '0; prev_ack = 1'b0; nw = 0;
    @(negedge clk);
    rd_req = 1'b1; rd_addr = raddr;
    for (int c = 0; c < 52; c++) begin
      if (c > 0) @(negedge clk);
      exp_we  = (c >= 6) && (c <= 46) && (((c - 6) % 5) == 0);
      exp_ack = (c >= 1) && !exp_we;
      exp_rdy = !((c == 9) || (c == 10));
      n_cmp++; if (ram_we !== exp_we) begin n_err++; $display("FAIL fill_we c=%0d: got %b expected %b", c, ram_we, exp_we); end
      n_cmp++; if (rd_ack !== exp_ack) begin n_err++; $display("FAIL fill_ack c=%0d: got %b expected %b", c, rd_ack, exp_ack); end
      n_cmp++; if (wr_ready !== exp_rdy) begin n_err++; $display("FAIL fill_ready c=%0d: got %b expected %b", c, wr_ready, exp_rdy); end
      n_cmp++; if (rd_valid !== prev_ack) begin n_err++; $display("FAIL fill_valid c=%0d: got %b expected %b", c, rd_valid, prev_ack); end
      if (prev_ack) begin
        n_cmp++; if (rd_data !== (acked ^ 16'hA5A5)) begin n_err++;
          $display("FAIL fill_rdata c=%0d: got %h expected %h", c, rd_data, acked ^ 16'hA5A5); end
      end
      if (rd_ack) begin
        n_cmp++; if (ram_addr !== raddr) begin n_err++; $display("FAIL fill_raddr c=%0d: got %h expected %h", c, ram_addr, raddr); end
        acked = raddr[15:0];
        raddr = raddr + 20'd1;
        rd_addr = raddr;
      end
      if (ram_we) begin
        n_cmp++; if ({ram_addr, ram_wdata} !== {20'(32'h400 + nw), 16'(32'h1000 + nw)}) begin n_err++;
          $display("FAIL fill_wr n=%0d: got addr=%h data=%h expected addr=%h data=%h", nw, ram_addr, ram_wdata,
                   20'(32'h400 + nw), 16'(32'h1000 + nw)); end
        nw++;
      end
      prev_ack = exp_ack;
      wr_valid = (c <= 10); wr_x = 16'(c); wr_y = 16'd1; wr_pixel = 16'(32'h1000 + c);
    end
    rd_req = 1'b0; wr_valid = 1'b0;
    n_cmp++; if (nw != 9) begin n_err++; $display("FAIL fill_nwrites: got %0d expected 9", nw); end
    repeat (2) @(negedge clk);
  endtask

  // Reset with 5 queued writes and a read acknowledged but not yet returned.
  task automatic test_reset_mid();
    logic [19:0] raddr;
    raddr = 20'h50000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin rd_req = 1'b1; rd_addr = raddr; end
      if (rd_ack) begin raddr = raddr + 20'd1; rd_addr = raddr; end
      wr_valid = 1'b1; wr_x = 16'(20 + c); wr_y = 16'd4; wr_pixel = 16'(32'hBEE0 + c);
    end
    @(negedge clk);
    n_cmp++; if ({rd_ack, ram_we} !== 2'b10) begin n_err++; $display("FAIL rm_inflight: got ack,we=%b expected 10", {rd_ack, ram_we}); end
    reset_n = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    n_cmp++; if ({wr_ready, rd_ack, rd_valid, ram_we} !== 4'b0000) begin n_err++;
      $display("FAIL rm_in_reset: got %b expected 0000", {wr_ready, rd_ack, rd_valid, ram_we}); end
    n_cmp++; if (dropped !== 16'd0) begin n_err++; $display("FAIL rm_dropped: got %0d expected 0", dropped); end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if ({wr_ready, rd_ack, rd_valid, ram_we} !== 4'b1000) begin n_err++;
        $display("FAIL rm_after i=%0d: got rdy,ack,valid,we=%b expected 1000", i, {wr_ready, rd_ack, rd_valid, ram_we}); end
    end
    n_cmp++; if (dropped !== 16'd0) begin n_err++; $display("FAIL rm_dropped_after: got %0d expected 0", dropped); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_drop();
    test_back_to_back();
    test_read_write_collision();
    test_fill_streak();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
